// File: rtl/dec3to8.sv
// dec3to8 - registered 3-to-8 one-hot decoder with a self-checking second path.
//
// Two independent decoders produce the same one-hot value from {en, in}:
//   - a shift-based path (d1 -> out1)
//   - a case-statement path (d2 -> out2)
// Both results are registered, together with a flag that records whether the two
// combinational decodes disagreed. In correct logic the flag never asserts. It lets
// a select-line consumer, such as a bank or chip-select generator, detect a corrupted
// decode.
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  synchronous, active-high reset; clears all three outputs
//   en       in   1  decode enable; 0 forces an all-zero decode
//   in       in   3  binary select, 0..7
//   out1     out  8  registered decode, shift implementation
//   out2     out  8  registered decode, case implementation
//   mismatch out  1  registered flag, 1 when the two combinational decodes differed
//
// Timing: one cycle of latency. {en, in} sampled at edge N appears on the outputs
// after edge N. Reset dominates enable.

module dec3to8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] in,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic       mismatch
);

  logic [7:0] d1;
  logic [7:0] d2;

  // Shift path. A 3-bit shift amount on an 8-bit operand cannot overflow, so the
  // result is always exactly one-hot when enabled.
  always_comb begin
    d1 = 8'h00;
    if (en) begin
      d1 = 8'h01 << in;
    end
  end

  // Case path. This path deliberately shares no logic with the shift path, so a
  // fault in either one is visible as a disagreement. An X/Z select falls through
  // to the default and gives an all-zero decode.
  always_comb begin
    d2 = 8'h00;
    if (en) begin
      case (in)
        3'd0:    d2 = 8'h01;
        3'd1:    d2 = 8'h02;
        3'd2:    d2 = 8'h04;
        3'd3:    d2 = 8'h08;
        3'd4:    d2 = 8'h10;
        3'd5:    d2 = 8'h20;
        3'd6:    d2 = 8'h40;
        3'd7:    d2 = 8'h80;
        default: d2 = 8'h00;
      endcase
    end
  end

  // Each output has its own register, so the two paths remain independent up to
  // the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      out1 <= 8'h00;
    end else begin
      out1 <= d1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out2 <= 8'h00;
    end else begin
      out2 <= d2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch <= 1'b0;
    end else begin
      mismatch <= (d1 != d2);
    end
  end

endmodule

// File: tb/tb_dec3to8.sv
// Directed self-checking bench for dec3to8. Inputs change 1 time unit after a
// rising edge. Outputs are sampled 1 time unit after the next rising edge.
module tb_dec3to8;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] in;
  logic [7:0] out1;
  logic [7:0] out2;
  logic       mismatch;

  int n_cmp;
  int n_err;

  // Hand-written one-hot table, indexed by select value.
  logic [7:0] onehot [8];

  dec3to8 dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in       (in),
    .out1     (out1),
    .out2     (out2),
    .mismatch (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    in  = 3'd5;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if ({out1, out2, mismatch} !== {8'h00, 8'h00, 1'b0}) begin
        n_err++;
        $display("FAIL reset cycle %0d: out1=%h out2=%h mismatch=%b, want 00 00 0",
                 c, out1, out2, mismatch);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_disabled_sweep();
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in = 3'(i);
      tick();
      n_cmp++;
      if ({out1, out2, mismatch} !== {8'h00, 8'h00, 1'b0}) begin
        n_err++;
        $display("FAIL disabled in=%0d: out1=%h out2=%h mismatch=%b, want 00 00 0",
                 i, out1, out2, mismatch);
      end
    end
  endtask

  task automatic test_enabled_sweep();
    logic [7:0] exp_tbl [8];
    exp_tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in = 3'(i);
      tick();
      n_cmp++;
      if ({out1, out2, mismatch} !== {exp_tbl[i], exp_tbl[i], 1'b0}) begin
        n_err++;
        $display("FAIL enabled in=%0d: out1=%h out2=%h mismatch=%b, want %h %h 0",
                 i, out1, out2, mismatch, exp_tbl[i], exp_tbl[i]);
      end
    end
  endtask

  task automatic test_enable_transition();
    logic [3:0] vec [3];
    logic [7:0] exp_tbl [3];
    vec     = '{4'b0_110, 4'b1_111, 4'b1_000};
    exp_tbl = '{8'h00, 8'h80, 8'h01};
    for (int i = 0; i < 3; i++) begin
      {en, in} = vec[i];
      tick();
      n_cmp++;
      if ({out1, out2, mismatch} !== {exp_tbl[i], exp_tbl[i], 1'b0}) begin
        n_err++;
        $display("FAIL transition step %0d: out1=%h out2=%h mismatch=%b, want %h %h 0",
                 i, out1, out2, mismatch, exp_tbl[i], exp_tbl[i]);
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic       rst_seq [3];
    logic [7:0] exp_tbl [3];
    rst_seq = '{1'b0, 1'b1, 1'b0};
    exp_tbl = '{8'h08, 8'h00, 8'h08};
    en = 1'b1;
    in = 3'd3;
    for (int i = 0; i < 3; i++) begin
      rst = rst_seq[i];
      tick();
      n_cmp++;
      if ({out1, out2, mismatch} !== {exp_tbl[i], exp_tbl[i], 1'b0}) begin
        n_err++;
        $display("FAIL midreset step %0d: out1=%h out2=%h mismatch=%b, want %h %h 0",
                 i, out1, out2, mismatch, exp_tbl[i], exp_tbl[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_exhaustive();
    // A fixed scrambled permutation of all 16 {en,in} codes.
    logic [3:0] order [16];
    logic [7:0] exp;
    order = '{4'hB, 4'h2, 4'hF, 4'h0, 4'h8, 4'h5, 4'hD, 4'h7,
              4'h9, 4'h3, 4'hE, 4'h1, 4'hC, 4'h6, 4'hA, 4'h4};
    for (int i = 0; i < 16; i++) begin
      {en, in} = order[i];
      exp = en ? onehot[in] : 8'h00;
      tick();
      n_cmp++;
      if ({out1, out2, mismatch} !== {exp, exp, 1'b0}) begin
        n_err++;
        $display("FAIL exhaustive en=%b in=%0d: out1=%h out2=%h mismatch=%b, want %h %h 0",
                 order[i][3], order[i][2:0], out1, out2, mismatch, exp, exp);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    onehot = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    rst    = 1'b1;
    en     = 1'b0;
    in     = 3'd0;
    #1;
    test_reset();
    test_disabled_sweep();
    test_enabled_sweep();
    test_enable_transition();
    test_midstream_reset();
    test_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
